// File: rtl/spi_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reg_bridge
// Purpose  : Bridges an SPI slave byte stream onto a simple register bus with
//            auto-incrementing burst writes and prefetched burst reads.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge #(
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic       valid,
    input  logic [7:0] rx_data,
    input  logic       read,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR       = 3'd2,
        RD_FETCH = 3'd3,
        RD_WAIT  = 3'd4,
        RD_READY = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_busy_d;
    logic       r_load;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic [7:0] r_txbuf;
    logic [7:0] r_tx_data;
    logic       r_frame_done;
    logic       r_underrun;
    logic [7:0] w_tx_next;
    logic       w_reg_re;
    logic       w_busy_rise;
    logic       w_busy_fall;

    assign w_busy_rise = busy & ~r_busy_d;
    assign w_busy_fall = ~busy & r_busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tx_next    = STATUS_BYTE;
        w_reg_re     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_busy_rise) begin
                    w_next_state = CMD;
                end
            end
            CMD: begin
                if (w_busy_fall) begin
                    w_next_state = IDLE;
                end else if (valid) begin
                    w_next_state = rx_data[7] ? RD_FETCH : WR;
                end
            end
            WR: begin
                w_tx_next = 8'h00;
                if (w_busy_fall) begin
                    w_next_state = IDLE;
                end
            end
            RD_FETCH: begin
                w_tx_next = r_txbuf;
                // A frame ending here abandons the prefetch without a bus read
                w_reg_re  = ~w_busy_fall;
                w_next_state = w_busy_fall ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                w_tx_next    = r_txbuf;
                w_next_state = w_busy_fall ? IDLE : RD_READY;
            end
            RD_READY: begin
                w_tx_next = r_txbuf;
                if (w_busy_fall) begin
                    w_next_state = IDLE;
                end else if (r_load) begin
                    w_next_state = RD_FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Busy held high through reset must not look like a new frame start
            r_busy_d     <= 1'b1;
            r_load       <= 1'b0;
            r_addr       <= 7'd0;
            r_wdata      <= 8'd0;
            r_we         <= 1'b0;
            r_txbuf      <= 8'd0;
            r_tx_data    <= STATUS_BYTE;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_busy_d     <= busy;
            r_load       <= read & (r_state == RD_READY);
            r_we         <= 1'b0;
            r_frame_done <= w_busy_fall & (r_state != IDLE);

            // Freeze the MISO byte across the slave's sample window
            if (!read) begin
                r_tx_data <= w_tx_next;
            end

            if ((r_state == IDLE) && w_busy_rise) begin
                r_underrun <= 1'b0;
            end else if (read && ((r_state == RD_FETCH) || (r_state == RD_WAIT))) begin
                r_underrun <= 1'b1;
            end

            // A write byte arriving with the frame end still gets committed
            if ((r_state == WR) && valid) begin
                r_we    <= 1'b1;
                r_wdata <= rx_data;
            end

            if ((r_state == RD_WAIT) && !w_busy_fall) begin
                r_txbuf <= reg_rdata;
            end

            if ((r_state == CMD) && valid && !w_busy_fall) begin
                r_addr <= rx_data[6:0];
            end else if (r_we || ((r_state == RD_READY) && r_load && !w_busy_fall)) begin
                r_addr <= r_addr + 7'd1;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign reg_addr   = r_addr;
    assign reg_wdata  = r_wdata;
    assign reg_we     = r_we;
    assign reg_re     = w_reg_re;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_bridge
// Purpose  : Self-checking bench for spi_reg_bridge: directed vector table,
//            hand-written corner sequences and randomized frames vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

    localparam logic [7:0] c_status = 8'hA5;

    typedef struct packed {
        logic [7:0]      cmd;
        logic [2:0]      n;
        logic            coincide;
        logic [1:0][7:0] d;
        logic [2:0][7:0] exp_a;
        logic [2:0][7:0] exp_v;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       valid;
    logic [7:0] rx_data;
    logic       read;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_done;
    logic       underrun;

    logic       mem_init;
    logic [7:0] dev_mem [128];
    logic [7:0] ref_mem [128];

    logic [15:0] wr_q [$];
    logic [15:0] re_q [$];
    logic [7:0]  ld_q [$];
    logic [7:0]  frame_data [$];
    logic [15:0] exp_wr [$];
    logic [15:0] exp_re [$];
    logic [7:0]  exp_ld [$];
    int          fd_cnt = 0;
    int          both_cnt = 0;
    int          wr_base, re_base, fd_base;
    int          vectors = 0;
    int          miscompares = 0;

    spi_reg_bridge #(.STATUS_BYTE(c_status)) dut (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy),
        .valid      (valid),
        .rx_data    (rx_data),
        .read       (read),
        .tx_data    (tx_data),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [6:0] a);
        if (a == 7'd10) return 8'h3C;
        if (a == 7'd11) return 8'h4D;
        return 8'({1'b0, a} * 8'd29 + 8'd7);
    endfunction

    // Register file attached to the bus: read data one cycle after reg_re
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) dev_mem[i] <= init_val(7'(i));
        end else if (reg_we) begin
            dev_mem[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_re ? dev_mem[reg_addr] : 8'hEE;
    end

    always @(negedge clk) begin
        if (reg_we) wr_q.push_back({1'b0, reg_addr, reg_wdata});
        if (reg_re) re_q.push_back({9'd0, reg_addr});
        if (frame_done) fd_cnt++;
        if (reg_we && reg_re) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic mark();
        wr_base = wr_q.size();
        re_base = re_q.size();
        fd_base = fd_cnt;
    endtask

    // Slave model: per byte, load MISO (read strobe), then deliver MOSI byte
    task automatic run_frame(input logic [7:0] cmd, input int n, input bit coincide);
        logic [7:0] b;
        ld_q.delete();
        busy = 1'b1;
        for (int k = 0; k <= n; k++) begin
            repeat (4) tick();
            read = 1'b1;
            tick();
            read = 1'b0;
            ld_q.push_back(tx_data);
            repeat (56) tick();
            b = (k == 0) ? cmd : frame_data[k-1];
            rx_data = b;
            valid   = 1'b1;
            if (k == n && coincide) busy = 1'b0;
            tick();
            valid = 1'b0;
        end
        if (!coincide) begin
            repeat (4) tick();
            busy = 1'b0;
        end
        repeat (8) tick();
    endtask

    task automatic check_frame(input string tag);
        chk({tag, " write_count"}, wr_q.size() - wr_base, exp_wr.size());
        foreach (exp_wr[i])
            chk({tag, " write"}, (wr_base + i < wr_q.size()) ? wr_q[wr_base + i] : 16'hFFFF, exp_wr[i]);
        chk({tag, " fetch_count"}, re_q.size() - re_base, exp_re.size());
        foreach (exp_re[i])
            chk({tag, " fetch_addr"}, (re_base + i < re_q.size()) ? re_q[re_base + i] : 16'hFFFF, exp_re[i]);
        foreach (exp_ld[i])
            chk({tag, " miso_load"}, (i < ld_q.size()) ? {24'd0, ld_q[i]} : 32'hFFFF, exp_ld[i]);
        chk({tag, " frame_done"}, fd_cnt - fd_base, 1);
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic [2:0] n, input logic co,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic [7:0] v0, input logic [7:0] v1);
        vec_t t;
        t.cmd = cmd; t.n = n; t.coincide = co;
        t.d[0] = d0; t.d[1] = d1;
        t.exp_a[0] = a0; t.exp_a[1] = a1; t.exp_a[2] = a2;
        t.exp_v[0] = v0; t.exp_v[1] = v1; t.exp_v[2] = 8'h00;
        return t;
    endfunction

    initial begin
        vec_t       vecs [5];
        bit         is_rd;
        bit         co;
        int         n;
        logic [6:0] a;
        logic [6:0] aa;
        logic [7:0] b;

        // Write vectors: exp_a/exp_v are write address/data; read vectors:
        // exp_a are fetch addresses, exp_v the data bytes loaded to MISO.
        vecs[0] = mk(8'h05, 3'd2, 1'b0, 8'h11, 8'h22, 8'h05, 8'h06, 8'h00, 8'h11, 8'h22);
        vecs[1] = mk(8'h7F, 3'd2, 1'b0, 8'hAA, 8'hBB, 8'h7F, 8'h00, 8'h00, 8'hAA, 8'hBB);
        vecs[2] = mk(8'h8A, 3'd2, 1'b0, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h3C, 8'h4D);
        vecs[3] = mk(8'hFF, 3'd2, 1'b0, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h01, 8'hAA, 8'hBB);
        vecs[4] = mk(8'h20, 3'd2, 1'b1, 8'h77, 8'h66, 8'h20, 8'h21, 8'h00, 8'h77, 8'h66);

        rst = 1'b1; busy = 1'b0; valid = 1'b0; read = 1'b0; rx_data = 8'h00;
        mem_init = 1'b1;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(7'(i));
        repeat (3) tick();
        mem_init = 1'b0;

        chk("reset tx_data",    tx_data, c_status);
        chk("reset reg_addr",   reg_addr, 0);
        chk("reset reg_wdata",  reg_wdata, 0);
        chk("reset reg_we",     reg_we, 0);
        chk("reset reg_re",     reg_re, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset underrun",   underrun, 0);
        rst = 1'b0;
        tick();

        // Underrun: slave loads while the first fetch is still in flight
        mark();
        busy = 1'b1;
        repeat (4) tick();
        read = 1'b1; tick(); read = 1'b0;
        chk("underrun status_load", tx_data, c_status);
        repeat (10) tick();
        rx_data = 8'h8A; valid = 1'b1; tick(); valid = 1'b0;
        tick();
        read = 1'b1; tick(); read = 1'b0;
        chk("underrun tx_hold", tx_data, 8'h00);
        chk("underrun set", underrun, 1);
        repeat (10) tick();
        busy = 1'b0;
        repeat (4) tick();
        chk("underrun sticky", underrun, 1);
        chk("underrun frame_done", fd_cnt - fd_base, 1);
        chk("underrun fetch_count", re_q.size() - re_base, 1);
        busy = 1'b1;
        tick();
        chk("underrun clear", underrun, 0);
        busy = 1'b0;
        repeat (8) tick();

        for (int v = 0; v < 5; v++) begin
            frame_data.delete(); exp_wr.delete(); exp_re.delete(); exp_ld.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) frame_data.push_back(vecs[v].d[i]);
            exp_ld.push_back(c_status);
            if (vecs[v].cmd[7]) begin
                for (int i = 0; i < int'(vecs[v].n); i++) exp_ld.push_back(vecs[v].exp_v[i]);
                for (int i = 0; i <= int'(vecs[v].n); i++) exp_re.push_back({9'd0, vecs[v].exp_a[i][6:0]});
            end else begin
                for (int i = 0; i < int'(vecs[v].n); i++) begin
                    exp_ld.push_back(8'h00);
                    exp_wr.push_back({1'b0, vecs[v].exp_a[i][6:0], vecs[v].exp_v[i]});
                    ref_mem[vecs[v].exp_a[i][6:0]] = vecs[v].exp_v[i];
                end
            end
            mark();
            run_frame(vecs[v].cmd, int'(vecs[v].n), vecs[v].coincide);
            check_frame($sformatf("vec%0d", v));
        end

        // Reset while a read fetch is outstanding, busy kept high afterwards
        mark();
        busy = 1'b1;
        repeat (4) tick();
        read = 1'b1; tick(); read = 1'b0;
        repeat (10) tick();
        rx_data = 8'h8A; valid = 1'b1; tick(); valid = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst tx_data",    tx_data, c_status);
        chk("midrst reg_addr",   reg_addr, 0);
        chk("midrst reg_wdata",  reg_wdata, 0);
        chk("midrst reg_we",     reg_we, 0);
        chk("midrst reg_re",     reg_re, 0);
        chk("midrst frame_done", frame_done, 0);
        chk("midrst underrun",   underrun, 0);
        mark();
        repeat (10) tick();
        rx_data = 8'h8B; valid = 1'b1; tick(); valid = 1'b0;
        repeat (10) tick();
        chk("midrst no_fetch", re_q.size() - re_base, 0);
        chk("midrst no_write", wr_q.size() - wr_base, 0);
        chk("midrst idle_tx",  tx_data, c_status);
        busy = 1'b0;
        repeat (4) tick();
        chk("midrst no_frame_done", fd_cnt - fd_base, 0);
        repeat (4) tick();

        // Randomized frames against the byte-level model in ref_mem
        for (int f = 0; f < 40; f++) begin
            is_rd = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 3) == 0) ? 7'(7'h7D + 7'($urandom_range(0, 2)))
                                                : 7'($urandom_range(0, 127));
            n     = $urandom_range(1, 5);
            co    = !is_rd && ($urandom_range(0, 2) == 0);
            frame_data.delete(); exp_wr.delete(); exp_re.delete(); exp_ld.delete();
            exp_ld.push_back(c_status);
            for (int i = 0; i < n; i++) begin
                b  = 8'($urandom);
                aa = a + 7'(i);
                frame_data.push_back(b);
                if (is_rd) begin
                    exp_ld.push_back(ref_mem[aa]);
                end else begin
                    exp_ld.push_back(8'h00);
                    exp_wr.push_back({1'b0, aa, b});
                    ref_mem[aa] = b;
                end
            end
            if (is_rd) begin
                for (int i = 0; i <= n; i++) exp_re.push_back({9'd0, 7'(a + 7'(i))});
            end
            mark();
            run_frame({is_rd, a}, n, co);
            check_frame($sformatf("rand%0d", f));
        end

        chk("we_re_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
